// File: rtl/caf_pkg.sv
// rtl/caf_pkg.sv - shared state encoding and default widths for the CAF sample path
package caf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_WAIT   = 2'd2
   } caf_state_t;

   localparam int default_i_bits       = 12;
   localparam int default_q_bits       = 12;
   localparam int default_index_bits   = 4;
   localparam int default_out_max_bits = 4;

endpackage

// File: rtl/caf_frame_streamer_if.sv
// rtl/caf_frame_streamer_if.sv - sample stream and peak result handshake toward argmax
interface caf_frame_streamer_if
   import caf_pkg::*;
#(
   parameter int i_bits       = default_i_bits,
   parameter int q_bits       = default_q_bits,
   parameter int index_bits   = default_index_bits,
   parameter int out_max_bits = default_out_max_bits
);

   logic                     m_axis_tvalid;
   logic signed [i_bits-1:0] xi;
   logic signed [q_bits-1:0] xq;
   logic                     s_axis_tready;
   logic                     res_tvalid;
   logic                     res_tready;
   logic [out_max_bits-1:0]  res_max;
   logic [index_bits-1:0]    res_index;

   modport master (
      output m_axis_tvalid, xi, xq, res_tready,
      input  s_axis_tready, res_tvalid, res_max, res_index
   );

   modport slave (
      input  m_axis_tvalid, xi, xq, res_tready,
      output s_axis_tready, res_tvalid, res_max, res_index
   );

endinterface

// File: rtl/caf_sample_ram.sv
// rtl/caf_sample_ram.sv - one-frame I/Q buffer, one write port, one synchronous read port
module caf_sample_ram #(
   parameter int depth     = 10,
   parameter int addr_bits = 4,
   parameter int data_bits = 24
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [addr_bits-1:0] wr_addr,
   input  logic [data_bits-1:0] wr_data,
   input  logic                 re,
   input  logic [addr_bits-1:0] rd_addr,
   output logic [data_bits-1:0] rd_data
);

   logic [data_bits-1:0] mem [depth];

   // write, and read with new data forwarded when both ports hit the same address
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
      if (re) begin
         rd_data <= (we && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
      end
   end

endmodule

// File: rtl/caf_frame_streamer.sv
// rtl/caf_frame_streamer.sv - streams a stored I/Q frame to argmax and latches its peak result
module caf_frame_streamer
   import caf_pkg::*;
#(
   parameter int buffer_length  = 10,
   parameter int index_bits     = default_index_bits,
   parameter int out_max_bits   = default_out_max_bits,
   parameter int i_bits         = default_i_bits,
   parameter int q_bits         = default_q_bits,
   parameter int timeout_cycles = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [index_bits-1:0]    wr_addr,
   input  logic signed [i_bits-1:0] wr_xi,
   input  logic signed [q_bits-1:0] wr_xq,
   input  logic                     start,
   output logic                     busy,
   caf_frame_streamer_if.master     axis,
   output logic [out_max_bits-1:0]  peak_max,
   output logic [index_bits-1:0]    peak_index,
   output logic                     done,
   output logic                     err,
   output logic [15:0]              frame_count
);

   localparam int cnt_bits  = index_bits + 1;
   localparam int data_bits = i_bits + q_bits;
   localparam int tmo_bits  = $clog2(timeout_cycles + 1);

   localparam logic [cnt_bits-1:0] frame_len = cnt_bits'(buffer_length);
   localparam logic [cnt_bits-1:0] last_beat = cnt_bits'(buffer_length - 1);
   localparam logic [tmo_bits-1:0] tmo_last  = tmo_bits'(timeout_cycles - 1);

   caf_state_t state, state_nxt;

   logic [cnt_bits-1:0]  rd_addr;
   logic [cnt_bits-1:0]  beat_cnt;
   logic                 rd_pending;
   logic                 rd_issue;
   logic                 start_ok;
   logic [data_bits-1:0] ram_rd_data;
   logic                 ram_we;

   logic                 out_valid;
   logic [data_bits-1:0] out_data;
   logic                 skid_valid;
   logic [data_bits-1:0] skid_data;

   logic [tmo_bits-1:0]  tmo_cnt;
   logic                 xfer;
   logic                 out_free;
   logic                 last_xfer;
   logic                 res_take;
   logic                 tmo_hit;
   logic [1:0]           occ_after;

   assign ram_we    = wr_en && (state == ST_IDLE) && ({1'b0, wr_addr} < frame_len);
   assign xfer      = out_valid && axis.s_axis_tready;
   assign out_free  = !out_valid || xfer;
   assign last_xfer = xfer && (beat_cnt == last_beat);
   assign res_take  = (state == ST_WAIT) && axis.res_tvalid;
   assign tmo_hit   = (state == ST_WAIT) && !axis.res_tvalid && (tmo_cnt == tmo_last);

   // Samples held after this edge: output + skid + read in flight, minus the beat leaving now.
   // A new read may only be issued if its data will find a free slot next cycle.
   assign occ_after = 2'(out_valid) + 2'(skid_valid) + 2'(rd_pending) - 2'(xfer);

   assign busy               = (state != ST_IDLE);
   assign axis.res_tready    = (state == ST_WAIT);
   assign axis.m_axis_tvalid = out_valid;
   assign axis.xi            = out_data[data_bits-1:q_bits];
   assign axis.xq            = out_data[q_bits-1:0];

   caf_sample_ram #(
      .depth     (buffer_length),
      .addr_bits (index_bits),
      .data_bits (data_bits)
   ) u_ram (
      .clk     (clk),
      .we      (ram_we),
      .wr_addr (wr_addr),
      .wr_data ({wr_xi, wr_xq}),
      .re      (rd_issue),
      .rd_addr (rd_addr[index_bits-1:0]),
      .rd_data (ram_rd_data)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next state, read issue; address 0 is fetched in the start cycle to reach 2-cycle latency
   always_comb begin
      state_nxt = state;
      start_ok  = 1'b0;
      rd_issue  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_STREAM;
               start_ok  = 1'b1;
               rd_issue  = 1'b1;
            end
         end
         ST_STREAM: begin
            rd_issue = (rd_addr < frame_len) && (occ_after <= 2'd1);
            if (last_xfer) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (res_take || tmo_hit) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // read address and beat counters; both return to 0 whenever the FSM goes idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_addr    <= '0;
         beat_cnt   <= '0;
         rd_pending <= 1'b0;
      end else begin
         rd_pending <= rd_issue;
         if (state_nxt == ST_IDLE) begin
            rd_addr <= '0;
         end else if (rd_issue) begin
            rd_addr <= rd_addr + 1'b1;
         end
         if (state != ST_STREAM) begin
            beat_cnt <= '0;
         end else if (xfer) begin
            beat_cnt <= beat_cnt + 1'b1;
         end
      end
   end

   // output register fed from the skid entry first, then from the RAM; RAM data lands in skid on stall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (out_free) begin
         if (skid_valid) begin
            out_valid  <= 1'b1;
            out_data   <= skid_data;
            skid_valid <= rd_pending;
            skid_data  <= ram_rd_data;
         end else if (rd_pending) begin
            out_valid <= 1'b1;
            out_data  <= ram_rd_data;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (rd_pending) begin
         skid_valid <= 1'b1;
         skid_data  <= ram_rd_data;
      end
   end

   // timeout counter, result latch, done pulse, sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt     <= '0;
         peak_max    <= '0;
         peak_index  <= '0;
         done        <= 1'b0;
         err         <= 1'b0;
         frame_count <= '0;
      end else begin
         done <= 1'b0;
         if (state == ST_WAIT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end else begin
            tmo_cnt <= '0;
         end
         if (res_take) begin
            peak_max    <= axis.res_max;
            peak_index  <= axis.res_index;
            done        <= 1'b1;
            frame_count <= frame_count + 16'd1;
         end else if (tmo_hit) begin
            err <= 1'b1;
         end
         if (start_ok) begin
            err <= 1'b0;
         end
      end
   end

endmodule
